// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encoding and instruction opcodes shared by the TAP blocks
package jtag_tap_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;
  localparam logic [3:0] IR_IDCODE  = 4'b0001;
  localparam logic [3:0] IR_CTRL    = 4'b1000;
  localparam logic [3:0] IR_MEMACC  = 4'b1001;
  localparam logic [3:0] IR_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 1149.1 TAP state register and next-state logic
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t tap_state
);
  tap_state_t nxt;
  always_ff @(posedge tck) tap_state <= rst ? TEST_LOGIC_RESET : nxt;
  always_comb begin
    nxt = TEST_LOGIC_RESET;
    case (tap_state)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        nxt = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
  end
endmodule

// File: rtl/jtag_mem_tap.sv
// jtag_mem_tap: JTAG TAP with IDCODE, CTRL and MEMACC data registers driving
// the programming controller's request interface, all in the tck domain
module jtag_mem_tap
  import jtag_tap_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter int          MEM_DATA_WIDTH = 32,
  parameter int          IR_WIDTH       = 4,
  parameter logic [31:0] IDCODE_VAL     = 32'h1000_0001
) (
  input  logic                      tck,
  input  logic                      rst,
  input  logic                      tms,
  input  logic                      tdi,
  output logic                      tdo,
  output logic                      tdo_en,
  output logic                      jtag_en,
  output logic                      jtag_req_pulse,
  output logic                      jtag_we,
  output logic [MEM_ADDR_WIDTH-1:0] jtag_addr,
  output logic [MEM_DATA_WIDTH-1:0] jtag_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] jtag_rdata,
  output logic [3:0]                tap_state
);
  localparam int D = MEM_DATA_WIDTH;
  localparam int N = 1 + MEM_ADDR_WIDTH + MEM_DATA_WIDTH;
  tap_state_t st;
  logic [IR_WIDTH-1:0] ir, ir_sr;
  logic [N-1:0] dr_sr, dr_cap, dr_shift;
  logic is_idcode, is_ctrl, is_memacc, tlr_next, mem_update;
  jtag_tap_fsm u_fsm (.tck(tck), .rst(rst), .tms(tms), .tap_state(st));
  assign tap_state = st;
  assign is_idcode = ir == IR_WIDTH'(IR_IDCODE);
  assign is_ctrl = ir == IR_WIDTH'(IR_CTRL);
  assign is_memacc = ir == IR_WIDTH'(IR_MEMACC);
  // TEST_LOGIC_RESET is only entered from itself or SELECT_IR with tms high
  assign tlr_next = (st == TEST_LOGIC_RESET || st == SELECT_IR) && tms;
  assign mem_update = st == UPDATE_DR && is_memacc;
  assign tdo_en = st == SHIFT_IR || st == SHIFT_DR;
  assign tdo = st == SHIFT_IR ? ir_sr[0] : st == SHIFT_DR ? dr_sr[0] : 1'b0;
  // One shared shift register; tdi enters at the top of the selected DR length
  always_comb begin
    dr_cap = is_idcode ? N'(IDCODE_VAL) : is_ctrl ? N'(jtag_en) :
             is_memacc ? {1'b0, jtag_addr, jtag_rdata} : '0;
    dr_shift = is_idcode ? N'({tdi, dr_sr[31:1]}) : is_memacc ? {tdi, dr_sr[N-1:1]} : N'(tdi);
  end
  always_ff @(posedge tck) begin
    if (rst) begin
      ir             <= IR_WIDTH'(IR_IDCODE);
      ir_sr          <= '0;
      dr_sr          <= '0;
      jtag_en        <= 1'b0;
      jtag_req_pulse <= 1'b0;
      jtag_we        <= 1'b0;
      jtag_addr      <= '0;
      jtag_wdata     <= '0;
    end else begin
      ir             <= tlr_next ? IR_WIDTH'(IR_IDCODE) : st == UPDATE_IR ? ir_sr : ir;
      ir_sr          <= st == CAPTURE_IR ? IR_WIDTH'(IR_CAPTURE) : st == SHIFT_IR ? {tdi, ir_sr[IR_WIDTH-1:1]} : ir_sr;
      dr_sr          <= st == CAPTURE_DR ? dr_cap : st == SHIFT_DR ? dr_shift : dr_sr;
      jtag_en        <= tlr_next ? 1'b0 : (st == UPDATE_DR && is_ctrl) ? dr_sr[0] : jtag_en;
      jtag_req_pulse <= mem_update;
      jtag_we        <= mem_update && dr_sr[N-1];
      jtag_addr      <= mem_update ? dr_sr[N-2:D] : jtag_addr;
      jtag_wdata     <= mem_update ? dr_sr[D-1:0] : jtag_wdata;
    end
  end
endmodule

// File: tb/tb_jtag_mem_tap.sv
// tb_jtag_mem_tap: scoreboard bench; drivers queue expected scans/requests, a monitor compares them
module tb_jtag_mem_tap;
  typedef struct {int len; logic [63:0] val;} tdo_t;
  logic tck = 0, rst = 1, tms = 1, tdi = 0;
  logic tdo, tdo_en, jtag_en, jtag_req_pulse, jtag_we;
  logic [9:0] jtag_addr;
  logic [31:0] jtag_wdata, jtag_rdata = 0;
  logic [3:0] tap_state;
  int checks = 0, errors = 0;
  tdo_t tdo_q[$];
  logic [42:0] req_q[$];
  jtag_mem_tap dut (
    .tck(tck), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .jtag_en(jtag_en), .jtag_req_pulse(jtag_req_pulse), .jtag_we(jtag_we),
    .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata), .jtag_rdata(jtag_rdata),
    .tap_state(tap_state)
  );
  always #5 tck = ~tck;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask
  task automatic scan_ir(input logic [3:0] v);
    tdo_q.push_back('{4, 64'h5});
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1, 0); tick(0, 0);
  endtask
  task automatic scan_dr(input int len, input logic [63:0] din, input logic [63:0] cap);
    tdo_q.push_back('{len, cap});
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < len; i++) tick(i == len - 1, din[i]);
    tick(1, 0); tick(0, 0);
  endtask
  // Monitor: a tdo_en burst ends a scan; jtag_req_pulse presents a request
  initial begin
    logic [63:0] got, m;
    int cnt;
    tdo_t e;
    logic [42:0] r;
    got = 0;
    cnt = 0;
    forever begin
      @(negedge tck);
      if (tdo_en) begin
        got[cnt] = tdo;
        cnt++;
      end else if (cnt > 0) begin
        if (tdo_q.size() == 0) chk("unexpected_scan", 64'(cnt), 64'd0);
        else begin
          e = tdo_q.pop_front();
          m = (64'd1 << e.len) - 64'd1;
          chk("scan_len", 64'(cnt), 64'(e.len));
          chk("scan_tdo", got & m, e.val & m);
        end
        cnt = 0;
        got = 0;
      end
      if (jtag_req_pulse === 1'b1) begin
        if (req_q.size() == 0) chk("unexpected_req", {jtag_we, jtag_addr, jtag_wdata}, 64'd0);
        else begin
          r = req_q.pop_front();
          chk("req", {jtag_we, jtag_addr, jtag_wdata}, 64'(r));
        end
      end
      if (jtag_we === 1'b1 && jtag_req_pulse !== 1'b1) chk("we_without_req", 64'd1, 64'd0);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge tck);
    #1;
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_outs", {jtag_en, jtag_req_pulse, jtag_we, tdo_en, tdo}, 64'd0);
    chk("rst_addr_wdata", {jtag_addr, jtag_wdata}, 64'd0);
    rst = 0;
    tick(0, 0);
    scan_dr(32, 64'd0, 64'h1000_0001);
    tdo_q.push_back('{1, 64'h1});
    tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (5) tick(1, 0);
    chk("tms5_from_shift_dr", 64'(tap_state), 64'hF);
    tick(0, 0);
    scan_ir(4'b1000);
    scan_dr(1, 64'd1, 64'd0);
    chk("ctrl_en_set", 64'(jtag_en), 64'd1);
    scan_dr(1, 64'd1, 64'd1);
    repeat (5) tick(1, 0);
    chk("tlr_clears_en", 64'(jtag_en), 64'd0);
    chk("tlr_state", 64'(tap_state), 64'hF);
    tick(0, 0);
    scan_ir(4'b1001);
    req_q.push_back({1'b1, 10'h2A5, 32'hDEAD_BEEF});
    scan_dr(43, 64'({1'b1, 10'h2A5, 32'hDEAD_BEEF}), 64'd0);
    chk("wr_addr", 64'(jtag_addr), 64'h2A5);
    chk("wr_wdata", 64'(jtag_wdata), 64'hDEAD_BEEF);
    chk("wr_pulse_hi", {jtag_req_pulse, jtag_we}, 64'd3);
    tick(0, 0);
    chk("wr_pulse_lo", {jtag_req_pulse, jtag_we}, 64'd0);
    scan_ir(4'b1111);
    chk("ir_change_keeps", {jtag_en, jtag_addr, jtag_wdata}, 64'({1'b0, 10'h2A5, 32'hDEAD_BEEF}));
    scan_dr(1, 64'd1, 64'd0);
    scan_ir(4'b1001);
    req_q.push_back({1'b0, 10'h010, 32'h0});
    scan_dr(43, 64'({1'b0, 10'h010, 32'h0}), 64'({1'b0, 10'h2A5, 32'h0}));
    repeat (8) tick(0, 0);
    jtag_rdata = 32'hCAFE_F00D;
    req_q.push_back({1'b0, 10'h010, 32'h0});
    scan_dr(43, 64'({1'b0, 10'h010, 32'h0}), 64'({1'b0, 10'h010, 32'hCAFE_F00D}));
    tdo_q.push_back('{21, 64'({1'b0, 10'h010, 32'hCAFE_F00D})});
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 20; i++) tick(0, 1'b1);
    rst = 1;
    tick(1, 0); tick(1, 0);
    rst = 0;
    chk("midscan_rst_state", 64'(tap_state), 64'hF);
    chk("midscan_rst_outs", {jtag_en, jtag_req_pulse, jtag_we, jtag_addr, jtag_wdata}, 64'd0);
    repeat (4) tick(1, 0);
    repeat (4) tick(0, 0);
    chk("midscan_no_req", 64'(jtag_addr), 64'd0);
    chk("scan_q_empty", 64'(tdo_q.size()), 64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
